// File: rtl/vec_mem_sequencer_if.sv
// Request, memory and response signals of the vector load/store sequencer.
// The sequencer connects to the slave modport; decode stage and memory use the master modport.
interface vec_mem_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned OFF_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_store;
  logic                     req_vector;
  logic [ADDR_W-1:0]        req_addr;
  logic [DATA_W*LANES-1:0]  req_wdata;

  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_re;
  logic                     mem_we;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;

  logic [OFF_W-1:0]         offset;
  logic                     busy;
  logic                     rsp_valid;
  logic [DATA_W*LANES-1:0]  rsp_data;

  modport master (
    output req_valid, req_store, req_vector, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_re, mem_we, mem_wdata, offset, busy, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_store, req_vector, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_re, mem_we, mem_wdata, offset, busy, rsp_valid, rsp_data
  );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Load/store sequencer: turns one LD/ST/VLD/VST request into 1 or LANES word accesses
// and assembles load data into a full-vector response. All outputs are registered.
module vec_mem_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input logic                clk,
  input logic                reset,
  vec_mem_sequencer_if.slave bus
);
  localparam int unsigned OFF_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned VEC_W = DATA_W * LANES;

  typedef enum logic [1:0] {StIdle, StAccess, StDrain, StResp} state_e;

  state_e              state_q;
  logic                store_q;
  logic                vector_q;
  logic [VEC_W-1:0]    wdata_q;
  logic [VEC_W-1:0]    asm_q;
  logic [VEC_W-1:0]    asm_d;
  logic [OFF_W-1:0]    lane_q;
  logic [OFF_W-1:0]    lane_next;
  logic [OFF_W-1:0]    cap_lane_q;
  logic                cap_q;
  logic                ready_q;
  logic                re_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   next_wdata;
  logic                rsp_valid_q;
  logic [VEC_W-1:0]    rsp_data_q;
  logic                last_lane;

  assign lane_next = lane_q + 1'b1;
  assign last_lane = !vector_q || (lane_q == OFF_W'(LANES - 1));

  // Read data lags its strobe by one cycle, so capture uses the delayed lane index.
  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < int'(LANES); i++) begin
      if (cap_q && (cap_lane_q == OFF_W'(i))) asm_d[i*DATA_W +: DATA_W] = bus.mem_rdata;
    end
  end

  always_comb begin
    next_wdata = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lane_next == OFF_W'(i)) next_wdata = wdata_q[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      store_q     <= 1'b0;
      vector_q    <= 1'b0;
      wdata_q     <= '0;
      asm_q       <= '0;
      lane_q      <= '0;
      cap_lane_q  <= '0;
      cap_q       <= 1'b0;
      ready_q     <= 1'b1;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      cap_q       <= re_q;
      cap_lane_q  <= lane_q;
      asm_q       <= asm_d;
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            state_q     <= StAccess;
            ready_q     <= 1'b0;
            store_q     <= bus.req_store;
            vector_q    <= bus.req_vector;
            wdata_q     <= bus.req_wdata;
            addr_q      <= bus.req_addr;
            lane_q      <= '0;
            we_q        <= bus.req_store;
            re_q        <= !bus.req_store;
            mem_wdata_q <= bus.req_store ? bus.req_wdata[DATA_W-1:0] : '0;
          end
        end
        StAccess: begin
          if (last_lane) begin
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            addr_q      <= '0;
            mem_wdata_q <= '0;
            lane_q      <= '0;
            state_q     <= store_q ? StResp : StDrain;
            rsp_valid_q <= store_q;
          end else begin
            lane_q      <= lane_next;
            addr_q      <= addr_q + 1'b1;
            mem_wdata_q <= store_q ? next_wdata : '0;
          end
        end
        StDrain: begin
          // Final lane lands this cycle; a scalar load zeroes the upper lanes.
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= vector_q ? asm_d : VEC_W'(asm_d[DATA_W-1:0]);
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = !ready_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_re    = re_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.offset    = lane_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: synchronous memory model, shadow-memory reference,
// directed cases followed by randomized load/store traffic.
module tb_vec_mem_sequencer;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vec_mem_sequencer_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

  vec_mem_sequencer #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int checks = 0;
  int failures = 0;
  logic [31:0]  ref_mem [256];
  logic [127:0] exp_rsp = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_offset", bus.offset, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
  endtask

  task automatic junk_fields();
    bus.req_store  = 1'($urandom);
    bus.req_vector = 1'($urandom);
    bus.req_addr   = 8'($urandom);
    bus.req_wdata  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Issues one request and checks every cycle until its response. hold keeps req_valid high
  // with junk fields afterwards; abort_at>0 asserts reset in that cycle after the checks.
  task automatic do_op(input bit st, input bit vec, input logic [7:0] a,
                       input logic [127:0] wd, input bit hold, input int abort_at);
    int n;
    int r;
    logic [127:0] new_rsp;
    n = vec ? 4 : 1;
    r = st ? n + 1 : n + 2;
    new_rsp = exp_rsp;
    if (!st) begin
      new_rsp = '0;
      for (int i = 0; i < n; i++) new_rsp[32*i +: 32] = ref_mem[(int'(a) + i) % 256];
    end
    @(negedge clk);
    chk("ready_before_accept", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_vector = vec;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    for (int j = 1; j <= r; j++) begin
      bit acc;
      @(negedge clk);
      junk_fields();
      bus.req_valid = hold;
      acc = (j <= n);
      chk("req_ready", bus.req_ready, 0);
      chk("busy", bus.busy, 1);
      chk("mem_we", bus.mem_we, st && acc);
      chk("mem_re", bus.mem_re, !st && acc);
      chk("offset", bus.offset, acc ? j - 1 : 0);
      if (acc) begin
        chk("mem_addr", bus.mem_addr, (int'(a) + j - 1) % 256);
        if (st) chk("mem_wdata", bus.mem_wdata, wd[32*(j-1) +: 32]);
      end
      chk("rsp_valid", bus.rsp_valid, j == r);
      chk("rsp_data", bus.rsp_data, (j == r) ? new_rsp : exp_rsp);
      if (j == abort_at) begin
        reset = 1'b0;
        #1;
        chk_reset();
        if (st) for (int i = 0; i < j - 1 && i < n; i++) ref_mem[(int'(a) + i) % 256] = wd[32*i +: 32];
        exp_rsp = '0;
        return;
      end
    end
    if (st) begin
      for (int i = 0; i < n; i++) begin
        ref_mem[(int'(a) + i) % 256] = wd[32*i +: 32];
        chk("mem_content", mem[(int'(a) + i) % 256], wd[32*i +: 32]);
      end
    end
    exp_rsp = new_rsp;
  endtask

  initial begin
    logic [7:0] base;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    junk_fields();
    repeat (3) @(negedge clk);
    chk_reset();
    reset = 1'b1;

    // Fill the whole memory so every later load has a known reference.
    for (int k = 0; k < 64; k++)
      do_op(1'b1, 1'b1, 8'(4 * k), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);

    do_op(1'b1, 1'b1, 8'd1, {32'd40, 32'd30, 32'd20, 32'd10}, 1'b0, 0);
    for (int i = 0; i < 4; i++) chk("vst_word", mem[1 + i], 10 * (i + 1));

    do_op(1'b1, 1'b1, 8'd0, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b0, 0);
    do_op(1'b0, 1'b1, 8'd0, '0, 1'b0, 0);
    chk("vld_data", bus.rsp_data, {32'd8, 32'd7, 32'd6, 32'd5});
    do_op(1'b0, 1'b0, 8'd2, '0, 1'b0, 0);
    chk("ld_data", bus.rsp_data, {32'd0, 32'd0, 32'd0, 32'd7});

    do_op(1'b0, 1'b1, 8'hFE, '0, 1'b0, 0);

    // Held-off second request: junk fields while busy, real fields only in the accept cycle.
    do_op(1'b1, 1'b1, 8'd20, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
    do_op(1'b0, 1'b1, 8'd20, '0, 1'b0, 0);

    base = 8'd100;
    do_op(1'b1, 1'b1, base, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 2);
    repeat (3) begin
      @(negedge clk);
      chk("abort_rsp_valid", bus.rsp_valid, 0);
      chk("abort_mem_we", bus.mem_we, 0);
    end
    chk("abort_word0", mem[base], ref_mem[base]);
    chk("abort_word1", mem[base + 8'd1], ref_mem[base + 8'd1]);
    reset = 1'b1;

    for (int k = 0; k < 40; k++)
      do_op(1'($urandom), 1'($urandom), 8'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);

    @(negedge clk);
    chk("final_ready", bus.req_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
